// File: rtl/vx_tcu_uop_sequencer_if.sv
// Handshake bundle between TCU dispatch, the uop sequencer and the FEDP execute/result ports.
interface vx_tcu_uop_sequencer_if #(
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_WIDTH-1:0] req_tag;
  logic [3:0]           req_m_last;
  logic [3:0]           req_n_last;

  logic                 uop_valid;
  logic                 uop_ready;
  logic [3:0]           uop_step_m;
  logic [3:0]           uop_step_n;
  logic [TAG_WIDTH-1:0] uop_tag;
  logic                 uop_last;

  logic                 cpl_valid;

  logic                 done_valid;
  logic                 done_ready;
  logic [TAG_WIDTH-1:0] done_tag;

  logic                 busy;
  logic                 err_cpl;

  // Sequencer side
  modport master (
    input  req_valid, req_tag, req_m_last, req_n_last, uop_ready, cpl_valid, done_ready,
    output req_ready, uop_valid, uop_step_m, uop_step_n, uop_tag, uop_last,
           done_valid, done_tag, busy, err_cpl
  );

  // Dispatch / FEDP / done-consumer side
  modport slave (
    output req_valid, req_tag, req_m_last, req_n_last, uop_ready, cpl_valid, done_ready,
    input  req_ready, uop_valid, uop_step_m, uop_step_n, uop_tag, uop_last,
           done_valid, done_tag, busy, err_cpl
  );
endinterface

// File: rtl/vx_tcu_uop_sequencer.sv
// Expands one MMA request into (step_m, step_n) FEDP micro-ops, throttled by an
// in-flight window, and reports completion once every micro-op has retired.
module vx_tcu_uop_sequencer #(
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  vx_tcu_uop_sequencer_if.master        bus
);

  localparam int unsigned STEP_W = 4;
  localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [STEP_W-1:0]    step_m_q, step_m_d;
  logic [STEP_W-1:0]    step_n_q, step_n_d;
  logic [STEP_W-1:0]    m_last_q, m_last_d;
  logic [STEP_W-1:0]    n_last_q, n_last_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 req_ready_q, req_ready_d;
  logic                 uop_valid_q, uop_valid_d;
  logic                 uop_last_q, uop_last_d;
  logic                 done_valid_q, done_valid_d;
  logic                 busy_q, busy_d;
  logic                 err_cpl_q, err_cpl_d;

  logic req_fire, uop_fire, cpl_ok, done_fire;

  // Handshake fires, window count, step walk and next state
  always_comb begin
    req_fire  = bus.req_valid && req_ready_q;
    uop_fire  = uop_valid_q && bus.uop_ready;
    cpl_ok    = bus.cpl_valid && (inflight_q != '0);
    done_fire = done_valid_q && bus.done_ready;

    inflight_d = inflight_q + CNT_W'(uop_fire) - CNT_W'(cpl_ok);
    err_cpl_d  = err_cpl_q | (bus.cpl_valid && (inflight_q == '0));

    step_m_d = step_m_q;
    step_n_d = step_n_q;
    m_last_d = m_last_q;
    n_last_d = n_last_q;
    tag_d    = tag_q;
    state_d  = state_q;

    if (req_fire) begin
      step_m_d = '0;
      step_n_d = '0;
      m_last_d = bus.req_m_last;
      n_last_d = bus.req_n_last;
      tag_d    = bus.req_tag;
    end else if (uop_fire) begin
      // n is the inner loop, m the outer one
      if (step_n_q == n_last_q) begin
        step_n_d = '0;
        step_m_d = step_m_q + STEP_W'(1);
      end else begin
        step_n_d = step_n_q + STEP_W'(1);
      end
    end

    case (state_q)
      S_IDLE:  if (req_fire)                state_d = S_ISSUE;
      S_ISSUE: if (uop_fire && uop_last_q)  state_d = S_DRAIN;
      S_DRAIN: if (inflight_d == '0)        state_d = S_DONE;
      S_DONE:  if (done_fire)               state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase

    // Outputs are decoded from next state so they leave the flops directly
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_valid_d = (state_d == S_DONE);
    uop_valid_d  = (state_d == S_ISSUE) && (inflight_d < CNT_MAX);
    uop_last_d   = (state_d == S_ISSUE) && (step_m_d == m_last_d) && (step_n_d == n_last_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      inflight_q   <= '0;
      step_m_q     <= '0;
      step_n_q     <= '0;
      m_last_q     <= '0;
      n_last_q     <= '0;
      tag_q        <= '0;
      req_ready_q  <= 1'b1;
      uop_valid_q  <= 1'b0;
      uop_last_q   <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_cpl_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      step_m_q     <= step_m_d;
      step_n_q     <= step_n_d;
      m_last_q     <= m_last_d;
      n_last_q     <= n_last_d;
      tag_q        <= tag_d;
      req_ready_q  <= req_ready_d;
      uop_valid_q  <= uop_valid_d;
      uop_last_q   <= uop_last_d;
      done_valid_q <= done_valid_d;
      busy_q       <= busy_d;
      err_cpl_q    <= err_cpl_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.uop_valid  = uop_valid_q;
  assign bus.uop_step_m = step_m_q;
  assign bus.uop_step_n = step_n_q;
  assign bus.uop_tag    = tag_q;
  assign bus.uop_last   = uop_last_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_tag   = tag_q;
  assign bus.busy       = busy_q;
  assign bus.err_cpl    = err_cpl_q;

endmodule

// File: tb/tb_vx_tcu_uop_sequencer.sv
// Table-driven and randomized checks of the uop sequencer against a queue-based model.
module tb_vx_tcu_uop_sequencer;

  localparam int MAXI = 8;

  logic clk = 1'b0;
  logic reset;

  vx_tcu_uop_sequencer_if #(.TAG_WIDTH(8)) bus ();

  vx_tcu_uop_sequencer #(.TAG_WIDTH(8), .MAX_INFLIGHT(MAXI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int m_last;
    int n_last;
    int ready_pct;
    int dmin;
    int dmax;
    int done_hold;
    int exp_uops;
  } req_vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int row     = -1;
  int exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [row %0d] %s: got 0x%0h required 0x%0h", row, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready",  32'(bus.req_ready), 1);
    chk("rst_uop_valid",  32'(bus.uop_valid), 0);
    chk("rst_step_m",     32'(bus.uop_step_m), 0);
    chk("rst_step_n",     32'(bus.uop_step_n), 0);
    chk("rst_uop_tag",    32'(bus.uop_tag), 0);
    chk("rst_uop_last",   32'(bus.uop_last), 0);
    chk("rst_done_valid", 32'(bus.done_valid), 0);
    chk("rst_done_tag",   32'(bus.done_tag), 0);
    chk("rst_busy",       32'(bus.busy), 0);
    chk("rst_err_cpl",    32'(bus.err_cpl), 0);
  endtask

  // One request end to end; bench plays FEDP with in-order random-latency retire
  task automatic run_req(input req_vec_t v);
    int exp_m[$];
    int exp_n[$];
    int due[$];
    int out_cnt = 0;
    int fired   = 0;
    int cyc     = 0;
    bit done_seen = 0;
    bit exp_valid, exp_done, rdy, cpl;
    int d;

    for (int m = 0; m <= v.m_last; m++)
      for (int n = 0; n <= v.n_last; n++) begin
        exp_m.push_back(m);
        exp_n.push_back(n);
      end

    chk("idle_req_ready", 32'(bus.req_ready), 1);
    chk("idle_uop_valid", 32'(bus.uop_valid), 0);
    bus.req_valid  = 1'b1;
    bus.req_tag    = 8'(v.tag);
    bus.req_m_last = 4'(v.m_last);
    bus.req_n_last = 4'(v.n_last);
    tick();
    bus.req_valid  = 1'b0;
    bus.req_tag    = 8'($urandom);
    bus.req_m_last = 4'($urandom);
    bus.req_n_last = 4'($urandom);

    while (cyc < 5000) begin
      exp_valid = (exp_m.size() > 0) && (out_cnt < MAXI);
      exp_done  = (exp_m.size() == 0) && (out_cnt == 0);
      chk("uop_valid",  32'(bus.uop_valid), 32'(exp_valid));
      chk("done_valid", 32'(bus.done_valid), 32'(exp_done));
      chk("busy",       32'(bus.busy), 1);
      chk("req_ready",  32'(bus.req_ready), 0);
      chk("err_cpl",    32'(bus.err_cpl), 32'(exp_err));
      if (exp_done) begin
        done_seen = 1;
        break;
      end
      if (exp_valid && bus.uop_valid) begin
        chk("uop_step_m", 32'(bus.uop_step_m), 32'(exp_m[0]));
        chk("uop_step_n", 32'(bus.uop_step_n), 32'(exp_n[0]));
        chk("uop_last",   32'(bus.uop_last), 32'(exp_m.size() == 1));
        chk("uop_tag",    32'(bus.uop_tag), 32'(v.tag));
      end
      rdy = ($urandom_range(99) < 32'(v.ready_pct));
      cpl = (due.size() > 0) && (due[0] <= cyc);
      bus.uop_ready = rdy;
      bus.cpl_valid = cpl;
      if (cpl) void'(due.pop_front());
      if (exp_valid && rdy) begin
        void'(exp_m.pop_front());
        void'(exp_n.pop_front());
        fired++;
        d = cyc + int'($urandom_range(v.dmax, v.dmin));
        if (due.size() > 0 && d < due[$]) d = due[$];
        due.push_back(d);
      end
      out_cnt = out_cnt + int'(exp_valid && rdy) - int'(cpl);
      tick();
      cyc++;
    end
    bus.uop_ready = 1'b0;
    bus.cpl_valid = 1'b0;
    if (!done_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL [row %0d] done_timeout: got no done after %0d cycles required done", row, cyc);
    end
    chk("uop_count", 32'(fired), 32'(v.exp_uops));

    for (int i = 0; i < v.done_hold; i++) begin
      bus.done_ready = 1'b0;
      chk("hold_done_valid", 32'(bus.done_valid), 1);
      chk("hold_done_tag",   32'(bus.done_tag), 32'(v.tag));
      chk("hold_req_ready",  32'(bus.req_ready), 0);
      tick();
    end
    bus.done_ready = 1'b1;
    chk("done_valid_fire", 32'(bus.done_valid), 1);
    chk("done_tag",        32'(bus.done_tag), 32'(v.tag));
    tick();
    bus.done_ready = 1'b0;
    chk("post_req_ready",  32'(bus.req_ready), 1);
    chk("post_busy",       32'(bus.busy), 0);
    chk("post_done_valid", 32'(bus.done_valid), 0);
    chk("post_uop_valid",  32'(bus.uop_valid), 0);
  endtask

  req_vec_t vecs[7];

  initial begin
    int fires;
    int out_cnt;
    int cyc;
    bit f;
    bit c;

    vecs[0] = '{tag: 'h5A, m_last: 0,  n_last: 0, ready_pct: 100, dmin: 3,  dmax: 3,  done_hold: 0, exp_uops: 1};
    vecs[1] = '{tag: 'h11, m_last: 1,  n_last: 2, ready_pct: 100, dmin: 1,  dmax: 1,  done_hold: 0, exp_uops: 6};
    vecs[2] = '{tag: 'h22, m_last: 3,  n_last: 3, ready_pct: 100, dmin: 12, dmax: 20, done_hold: 0, exp_uops: 16};
    vecs[3] = '{tag: 'h44, m_last: 2,  n_last: 4, ready_pct: 50,  dmin: 1,  dmax: 6,  done_hold: 0, exp_uops: 15};
    vecs[4] = '{tag: 'h55, m_last: 1,  n_last: 1, ready_pct: 60,  dmin: 2,  dmax: 5,  done_hold: 5, exp_uops: 4};
    vecs[5] = '{tag: 'h66, m_last: 15, n_last: 15, ready_pct: 70, dmin: 1,  dmax: 12, done_hold: 2, exp_uops: 256};
    vecs[6] = '{tag: 'hA5, m_last: 0,  n_last: 7, ready_pct: 40,  dmin: 1,  dmax: 3,  done_hold: 1, exp_uops: 8};

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_tag    = '0;
    bus.req_m_last = '0;
    bus.req_n_last = '0;
    bus.uop_ready  = 1'b0;
    bus.cpl_valid  = 1'b0;
    bus.done_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      row = i;
      run_req(vecs[i]);
      tick();
    end

    // Stray completion while idle
    row = 100;
    bus.cpl_valid = 1'b1;
    tick();
    bus.cpl_valid = 1'b0;
    exp_err = 1;
    chk("stray_err_cpl",   32'(bus.err_cpl), 1);
    chk("stray_req_ready", 32'(bus.req_ready), 1);
    chk("stray_busy",      32'(bus.busy), 0);

    // Window stall with explicit completions; inflight must still start at 0
    row = 101;
    bus.uop_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_tag    = 8'h33;
    bus.req_m_last = 4'd3;
    bus.req_n_last = 4'd3;
    tick();
    bus.req_valid = 1'b0;
    fires = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.uop_valid) fires++;
      tick();
    end
    chk("win_fill_count", 32'(fires), 8);
    chk("win_stall_valid", 32'(bus.uop_valid), 0);
    chk("win_stall_m", 32'(bus.uop_step_m), 2);
    chk("win_stall_n", 32'(bus.uop_step_n), 0);
    bus.cpl_valid = 1'b1;
    tick();
    bus.cpl_valid = 1'b0;
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.uop_valid) fires++;
      tick();
    end
    chk("win_one_more", 32'(fires), 1);
    bus.cpl_valid = 1'b1;
    tick();
    chk("win_b_valid", 32'(bus.uop_valid), 1);
    chk("win_b_n", 32'(bus.uop_step_n), 1);
    tick();
    bus.cpl_valid = 1'b0;
    chk("win_c_valid", 32'(bus.uop_valid), 1);
    chk("win_c_n", 32'(bus.uop_step_n), 2);
    tick();
    chk("win_d_valid", 32'(bus.uop_valid), 0);
    out_cnt = 8;
    fires = 0;
    cyc = 0;
    while (!bus.done_valid && cyc < 300) begin
      f = bus.uop_valid;
      c = (out_cnt > 0);
      bus.cpl_valid = c;
      if (f) fires++;
      tick();
      out_cnt = out_cnt + int'(f) - int'(c);
      cyc++;
    end
    bus.cpl_valid = 1'b0;
    chk("win_drain_fires", 32'(fires), 5);
    chk("win_done_valid", 32'(bus.done_valid), 1);
    chk("win_done_tag", 32'(bus.done_tag), 'h33);
    chk("win_err_sticky", 32'(bus.err_cpl), 1);
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    chk("win_idle", 32'(bus.req_ready), 1);

    // Reset in the middle of issue
    row = 102;
    bus.req_valid  = 1'b1;
    bus.req_tag    = 8'h77;
    bus.req_m_last = 4'd3;
    bus.req_n_last = 4'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_step_n", 32'(bus.uop_step_n), 3);
    chk("mid_busy", 32'(bus.busy), 1);
    bus.uop_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    exp_err = 0;
    tick();
    chk_reset_vals();
    row = 103;
    run_req('{tag: 'h78, m_last: 3, n_last: 3, ready_pct: 80, dmin: 1, dmax: 4, done_hold: 0, exp_uops: 16});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_tcu_uop_sequencer.md
# vx_tcu_uop_sequencer

Expands one tensor-core MMA request into a sequence of per-step FEDP micro-ops (step_m, step_n), throttles issue against a bounded in-flight window, and signals completion once every micro-op result has retired. It sits between the TCU dispatch stage and the FEDP execute unit. It drives that unit's execute-side valid/ready and observes its result-side fire to retire micro-ops.

## Interface
Parameters:
- TAG_WIDTH, 8: width of the opaque request tag (uuid/wid bundle), carried through unchanged.
- MAX_INFLIGHT, 8: maximum issued-but-unretired micro-ops; must be ≥1. Sized to match the FEDP metadata queue depth.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  MMA request valid.
- req_ready  out  1  sequencer idle and accepting a request.
- req_tag  in  TAG_WIDTH  request tag.
- req_m_last  in  4  last step_m index; issue covers step_m 0..req_m_last.
- req_n_last  in  4  last step_n index; issue covers step_n 0..req_n_last.
- uop_valid  out  1  micro-op valid toward FEDP execute.
- uop_ready  in  1  FEDP execute ready.
- uop_step_m  out  4  current step_m.
- uop_step_n  out  4  current step_n.
- uop_tag  out  TAG_WIDTH  latched request tag.
- uop_last  out  1  current micro-op is the final one of the request.
- cpl_valid  in  1  one FEDP result retired this cycle (result valid && ready).
- done_valid  out  1  request fully retired.
- done_ready  in  1  consumer accepts done.
- done_tag  out  TAG_WIDTH  tag of the completed request.
- busy  out  1  state != IDLE.
- err_cpl  out  1  sticky; set when cpl_valid arrives with zero in-flight.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req fire, latch tag, m_last and n_last; clear both step counters; go to ISSUE.
- ISSUE:
  - uop_valid = (inflight < MAX_INFLIGHT). There is no same-cycle completion bypass.
  - Order is n inner, m outer: (0,0),(0,1)..(0,n_last),(1,0)..
  - On uop fire: if step_n==n_last, then step_n←0 and step_m++; otherwise step_n++.
  - uop_last = (step_m==m_last && step_n==n_last).
  - A fire with uop_last set moves the FSM to DRAIN.
- DRAIN: stay until the updated inflight count is 0, then go to DONE.
- DONE:
  - done_valid=1 and done_tag=latched tag.
  - On done_ready, go to IDLE.
- inflight counter:
  - Width $clog2(MAX_INFLIGHT+1).
  - next = inflight + uop_fire − (cpl_valid && inflight!=0). A simultaneous fire and completion leaves the count unchanged.
  - cpl_valid with inflight==0 in any state is ignored for the count and sets err_cpl. err_cpl is cleared only by reset.
- Total micro-ops per request = (m_last+1)*(n_last+1), from 1 to 256.
- uop_step_m, uop_step_n, uop_tag and uop_last hold stable while uop_valid && !uop_ready.
- Reset at any time:
  - State←IDLE; inflight, step counters, latched tag and err_cpl←0.
  - Outputs after reset: req_ready=1, uop_valid=0, uop_step_m/n=0, uop_tag=0, uop_last=0, done_valid=0, done_tag=0, busy=0, err_cpl=0.
  - Completions already in the FEDP pipe are not tracked after reset; the FEDP unit is reset by the same reset.

## Timing
- req fire at cycle t → uop_valid is first asserted at t+1.
- With uop_ready tied high and no window stall, micro-ops issue one per cycle from t+1 to t+N.
- Last uop fire at cycle u → DRAIN at u+1. The final completion at cycle c (c ≥ u+1) → done_valid at c+1.
- done fire at cycle d → req_ready at d+1. Back-to-back requests are therefore separated by at least 1 idle cycle.
- req_ready depends only on state; there is no combinational path from req_valid.
- uop_valid depends only on registered state; there is no combinational path from uop_ready.

## Test plan
- Single step:
  - Stimulus: m_last=0, n_last=0, tag=0x5A, uop_ready=1, cpl 3 cycles after issue.
  - Required: exactly one uop (0,0) with uop_last=1; done_valid with tag 0x5A one cycle after cpl; then IDLE.
- Full 2×3 sweep:
  - Stimulus: m_last=1, n_last=2.
  - Required: uops in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); uop_last only on (1,2); six cpl pulses before done.
- Window stall:
  - Stimulus: MAX_INFLIGHT=8, m_last=3, n_last=3, no completions.
  - Required: 8 uops issue, then uop_valid=0 with inflight=8. One cpl pulse → exactly one further uop. A cpl in the same cycle as a uop fire keeps inflight unchanged.
- Backpressure:
  - Stimulus: uop_ready toggles randomly.
  - Required: step/tag/last stay stable while stalled; no step index is skipped or duplicated.
- Done backpressure and stray completion:
  - Stimulus: hold done_ready=0 for 5 cycles, then pulse cpl_valid while in IDLE.
  - Required: done_valid and done_tag held for 5 cycles; req_ready=0 meanwhile. The stray cpl sets err_cpl=1 and inflight stays 0.
- Reset mid-ISSUE:
  - Stimulus: assert reset after 3 of 16 uops.
  - Required: next cycle all outputs are at their reset values (req_ready=1, uop_valid=0, busy=0); a new request starts again from (0,0).
